// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the MIPS core and a host/debug requester.
// A host burst is capped at MAX_BURST cycles and is followed by CPU_SLOTS core cycles.
module dmem_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CPU_SLOTS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_in,
    output logic        cpu_enable,
    input  logic        cpu_mem_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    input  logic        host_req,
    input  logic        host_wr,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_gnt,
    output logic        host_ack,
    output logic [31:0] host_rdata,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int CW = (CPU_SLOTS > 1) ? $clog2(CPU_SLOTS) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [CW-1:0] COOL_INIT  = CW'(CPU_SLOTS - 1);

    typedef enum logic [1:0] {
        ST_CPU  = 2'd0,
        ST_HOST = 2'd1,
        ST_COOL = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [CW-1:0]   cool_cnt_q, cool_cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_CPU;
            burst_cnt_q <= '0;
            cool_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            cool_cnt_q  <= cool_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        cool_cnt_d  = cool_cnt_q;
        case (state_q)
            ST_CPU: begin
                if (host_req) begin
                    state_d     = ST_HOST;
                    burst_cnt_d = '0;
                end
            end
            ST_HOST: begin
                if (!host_req) begin
                    state_d = ST_CPU;
                end else if (burst_cnt_q == BURST_LAST) begin
                    state_d    = ST_COOL;
                    cool_cnt_d = COOL_INIT;
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            ST_COOL: begin
                // The window runs on clock cycles alone; requests only matter at its end.
                if (cool_cnt_q == '0) begin
                    if (host_req) begin
                        state_d     = ST_HOST;
                        burst_cnt_d = '0;
                    end else begin
                        state_d = ST_CPU;
                    end
                end else begin
                    cool_cnt_d = cool_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d     = ST_CPU;
                burst_cnt_d = '0;
                cool_cnt_d  = '0;
            end
        endcase
    end

    // Reset gates the strobes combinationally so a write in flight never commits.
    always_comb begin
        host_gnt   = reset && (state_q == ST_HOST);
        cpu_enable = reset && run_in && (state_q != ST_HOST);
        host_ack   = host_gnt && host_req;
        cpu_rdata  = mem_rdata;
        host_rdata = mem_rdata;
        if (host_gnt) begin
            mem_wr    = host_wr && host_req;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else begin
            mem_wr    = cpu_mem_wr && cpu_enable;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus a randomized run against
// a grant/burst/cooldown reference model and a word-level memory scoreboard.
module tb_dmem_arbiter;

    localparam int MB = 4;
    localparam int CS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_in;
    logic        cpu_enable;
    logic        cpu_mem_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        host_req, host_wr;
    logic [31:0] host_addr, host_wdata;
    logic        host_gnt, host_ack;
    logic [31:0] host_rdata;
    logic        mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] dmem [0:63];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mem_rdata = dmem[mem_addr[7:2]];
    always @(posedge clk) if (mem_wr) dmem[mem_addr[7:2]] <= mem_wdata;

    dmem_arbiter #(.MAX_BURST(MB), .CPU_SLOTS(CS)) dut (
        .clk(clk), .reset(reset), .run_in(run_in), .cpu_enable(cpu_enable),
        .cpu_mem_wr(cpu_mem_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .host_req(host_req), .host_wr(host_wr),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_ack(host_ack), .host_rdata(host_rdata), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_host();
        host_req   = 1'b0;
        host_wr    = 1'b0;
        cpu_mem_wr = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; run_in = 1'b1; host_req = 1'b1; host_wr = 1'b1;
        host_addr = 32'h0; host_wdata = 32'h0;
        cpu_mem_wr = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h0;
        repeat (2) tick();
        checks++; if (cpu_enable !== 1'b0) begin failures++; $display("FAIL rst_cpu_enable got=%b want=0", cpu_enable); end
        checks++; if (host_gnt !== 1'b0) begin failures++; $display("FAIL rst_host_gnt got=%b want=0", host_gnt); end
        checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL rst_host_ack got=%b want=0", host_ack); end
        checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL rst_mem_wr got=%b want=0", mem_wr); end
        reset = 1'b1; cpu_mem_wr = 1'b0;
        #1;
        checks++; if (cpu_enable !== 1'b1) begin failures++; $display("FAIL rel_cpu_enable got=%b want=1", cpu_enable); end
        checks++; if (host_gnt !== 1'b0) begin failures++; $display("FAIL rel_host_gnt_c1 got=%b want=0", host_gnt); end
        tick();
        checks++; if (host_gnt !== 1'b1) begin failures++; $display("FAIL rel_host_gnt_c2 got=%b want=1", host_gnt); end
        checks++; if (cpu_enable !== 1'b0) begin failures++; $display("FAIL rel_cpu_enable_c2 got=%b want=0", cpu_enable); end
        release_host();
        $display("test_reset done");
    endtask

    task automatic test_host_write_read();
        run_in = 1'b1; host_req = 1'b1; host_wr = 1'b1;
        host_addr = 32'h10; host_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (host_gnt !== 1'b0) begin failures++; $display("FAIL wr_gnt_latency got=%b want=0", host_gnt); end
        tick();
        checks++; if (host_ack !== 1'b1) begin failures++; $display("FAIL wr_ack got=%b want=1", host_ack); end
        checks++; if (cpu_enable !== 1'b0) begin failures++; $display("FAIL wr_cpu_enable got=%b want=0", cpu_enable); end
        checks++; if (mem_wr !== 1'b1) begin failures++; $display("FAIL wr_mem_wr got=%b want=1", mem_wr); end
        tick();
        host_wr = 1'b0;
        #1;
        checks++; if (host_ack !== 1'b1) begin failures++; $display("FAIL rd_ack got=%b want=1", host_ack); end
        checks++; if (host_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h want=deadbeef", host_rdata); end
        checks++; if (cpu_enable !== 1'b0) begin failures++; $display("FAIL rd_cpu_enable got=%b want=0", cpu_enable); end
        tick();
        host_req = 1'b0; host_wr = 1'b1;
        #1;
        checks++; if (host_gnt !== 1'b1 || host_ack !== 1'b0 || mem_wr !== 1'b0) begin
            failures++; $display("FAIL idle_host gnt/ack/wr got=%b%b%b want=100", host_gnt, host_ack, mem_wr); end
        tick();
        checks++; if (cpu_enable !== 1'b1 || host_gnt !== 1'b0) begin
            failures++; $display("FAIL back_to_cpu en/gnt got=%b%b want=10", cpu_enable, host_gnt); end
        host_wr = 1'b0;
        $display("test_host_write_read done");
    endtask

    task automatic test_burst_limit();
        run_in = 1'b1; host_req = 1'b1; host_wr = 1'b0; host_addr = 32'h10;
        tick();
        for (int i = 0; i < 10; i++) begin
            logic exp_ack;
            exp_ack = (i < MB) || (i >= MB + CS);
            #1;
            checks++; if (host_ack !== exp_ack || cpu_enable !== !exp_ack) begin
                failures++; $display("FAIL burst_cycle%0d ack/en got=%b%b want=%b%b", i, host_ack, cpu_enable, exp_ack, !exp_ack); end
            tick();
        end
        release_host();
        $display("test_burst_limit done");
    endtask

    task automatic test_core_write_in_cool();
        run_in = 1'b1; host_req = 1'b1; host_wr = 1'b0; host_addr = 32'h40;
        tick();
        for (int i = 0; i < MB + CS; i++) begin
            if (i >= MB) begin
                cpu_mem_wr = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hC0DE0000 + 32'(i);
            end
            #1;
            if (i == MB) begin
                checks++; if (mem_wr !== 1'b1 || mem_addr !== 32'h40 || host_ack !== 1'b0) begin
                    failures++; $display("FAIL cool_cpu_write wr/addr/ack got=%b/%h/%b want=1/00000040/0", mem_wr, mem_addr, host_ack); end
            end
            tick();
        end
        cpu_mem_wr = 1'b0;
        #1;
        checks++; if (host_ack !== 1'b1 || host_rdata !== 32'hC0DE0005) begin
            failures++; $display("FAIL cool_readback ack/data got=%b/%h want=1/c0de0005", host_ack, host_rdata); end
        release_host();
        $display("test_core_write_in_cool done");
    endtask

    task automatic test_early_release();
        run_in = 1'b1; host_req = 1'b1; host_wr = 1'b1;
        host_addr = 32'h30; host_wdata = 32'hA5A5A5A5;
        #1;
        checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL early_pre_ack got=%b want=0", host_ack); end
        tick();
        checks++; if (host_ack !== 1'b1) begin failures++; $display("FAIL early_ack1 got=%b want=1", host_ack); end
        tick();
        host_addr = 32'h34; host_wdata = 32'h5A5A5A5A;
        #1;
        checks++; if (host_ack !== 1'b1) begin failures++; $display("FAIL early_ack2 got=%b want=1", host_ack); end
        tick();
        host_req = 1'b0; host_addr = 32'h38; host_wdata = 32'hFFFFFFFF;
        #1;
        checks++; if (host_gnt !== 1'b1 || host_ack !== 1'b0 || mem_wr !== 1'b0 || cpu_enable !== 1'b0) begin
            failures++; $display("FAIL early_idle gnt/ack/wr/en got=%b%b%b%b want=1000", host_gnt, host_ack, mem_wr, cpu_enable); end
        tick();
        checks++; if (cpu_enable !== 1'b1 || host_gnt !== 1'b0) begin
            failures++; $display("FAIL early_cpu en/gnt got=%b%b want=10", cpu_enable, host_gnt); end
        run_in = 1'b0;
        #1;
        checks++; if (cpu_enable !== 1'b0) begin failures++; $display("FAIL early_run_off got=%b want=0", cpu_enable); end
        run_in = 1'b1; host_wr = 1'b0;
        $display("test_early_release done");
    endtask

    task automatic test_reset_mid_burst();
        run_in = 1'b1; host_req = 1'b1; host_wr = 1'b1;
        host_addr = 32'h20; host_wdata = 32'h11111111;
        tick(); tick();
        host_req = 1'b0;
        tick(); tick();
        host_req = 1'b1; host_addr = 32'h24; host_wdata = 32'h22222222;
        tick(); tick();
        host_addr = 32'h20; host_wdata = 32'h33333333;
        #1;
        checks++; if (mem_wr !== 1'b1) begin failures++; $display("FAIL mid_pre_wr got=%b want=1", mem_wr); end
        reset = 1'b0;
        #1;
        checks++; if (mem_wr !== 1'b0 || host_gnt !== 1'b0 || cpu_enable !== 1'b0) begin
            failures++; $display("FAIL mid_rst wr/gnt/en got=%b%b%b want=000", mem_wr, host_gnt, cpu_enable); end
        tick();
        reset = 1'b1; host_req = 1'b0; host_wr = 1'b0;
        #1;
        checks++; if (host_gnt !== 1'b0 || cpu_enable !== 1'b1) begin
            failures++; $display("FAIL mid_after gnt/en got=%b%b want=01", host_gnt, cpu_enable); end
        host_req = 1'b1;
        tick();
        checks++; if (host_ack !== 1'b1 || host_rdata !== 32'h11111111) begin
            failures++; $display("FAIL mid_keep ack/data got=%b/%h want=1/11111111", host_ack, host_rdata); end
        release_host();
        $display("test_reset_mid_burst done");
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [0:63];
        bit          ref_valid [0:63];
        bit          m_host;
        int          m_used, m_cool;
        logic        e_gnt, e_en, e_ack, e_wr;
        logic [31:0] e_addr, e_wdata;
        logic        last_ack;
        for (int k = 0; k < 64; k++) ref_valid[k] = 1'b0;
        reset = 1'b0; host_req = 1'b0; cpu_mem_wr = 1'b0;
        tick();
        reset = 1'b1;
        m_host = 1'b0; m_used = 0; m_cool = 0; last_ack = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!host_req || last_ack) begin
                host_req   = ($urandom_range(0, 99) < 60);
                host_wr    = $urandom_range(0, 1) == 1;
                host_addr  = 32'($urandom_range(0, 15)) * 4;
                host_wdata = $urandom;
            end
            run_in     = ($urandom_range(0, 7) != 0);
            cpu_mem_wr = $urandom_range(0, 1) == 1;
            cpu_addr   = 32'($urandom_range(0, 31)) * 4;
            cpu_wdata  = $urandom;
            #1;
            e_gnt   = m_host;
            e_en    = !m_host && run_in;
            e_ack   = m_host && host_req;
            e_wr    = m_host ? (host_wr && host_req) : (cpu_mem_wr && e_en);
            e_addr  = m_host ? host_addr : cpu_addr;
            e_wdata = m_host ? host_wdata : cpu_wdata;
            checks++; if (host_gnt !== e_gnt || cpu_enable !== e_en || host_ack !== e_ack) begin
                failures++; $display("FAIL rnd%0d gnt/en/ack got=%b%b%b want=%b%b%b", c, host_gnt, cpu_enable, host_ack, e_gnt, e_en, e_ack); end
            checks++; if (mem_wr !== e_wr || mem_addr !== e_addr || (e_wr && mem_wdata !== e_wdata)) begin
                failures++; $display("FAIL rnd%0d wr/addr/data got=%b/%h/%h want=%b/%h/%h", c, mem_wr, mem_addr, mem_wdata, e_wr, e_addr, e_wdata); end
            if (!e_wr && ref_valid[e_addr[7:2]]) begin
                checks++; if (host_rdata !== ref_mem[e_addr[7:2]] || cpu_rdata !== ref_mem[e_addr[7:2]]) begin
                    failures++; $display("FAIL rnd%0d rdata host/cpu got=%h/%h want=%h", c, host_rdata, cpu_rdata, ref_mem[e_addr[7:2]]); end
            end
            if (e_wr) begin
                ref_mem[e_addr[7:2]]   = e_wdata;
                ref_valid[e_addr[7:2]] = 1'b1;
            end
            // Grant lasts at most MB accesses, then CS cycles belong to the core.
            if (m_host) begin
                if (!host_req) m_host = 1'b0;
                else begin
                    m_used++;
                    if (m_used == MB) begin m_host = 1'b0; m_cool = CS; end
                end
            end else if (m_cool > 0) begin
                m_cool--;
                if (m_cool == 0 && host_req) begin m_host = 1'b1; m_used = 0; end
            end else if (host_req) begin
                m_host = 1'b1; m_used = 0;
            end
            last_ack = e_ack;
            tick();
        end
        release_host();
        $display("test_random done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_host_write_read();
        test_burst_limit();
        test_core_write_in_cool();
        test_early_release();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single data-memory port between the single-cycle MIPS core and an external host/debug requester (loader, inspector). When the host takes the port, the core is stalled through its `enable` input, so every core instruction either completes entirely or does not start. A bounded host burst followed by a guaranteed core window prevents either side from starving. The arbiter sits between `mips`, `dmem` and the host port in the top level.

## Interface
Parameters:
- `MAX_BURST`, 4: maximum consecutive host accesses per grant (≥1).
- `CPU_SLOTS`, 2: cycles the core owns the port after a full-length burst (≥1).

Ports:
- `clk`  in  1  processor clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run_in`  in  1  external run/enable request for the core.
- `cpu_enable`  out  1  drives `mips` enable.
- `cpu_mem_wr`  in  1  core write strobe.
- `cpu_addr`  in  32  core byte address.
- `cpu_wdata`  in  32  core write data.
- `cpu_rdata`  out  32  read data to the core.
- `host_req`  in  1  host access request; held high for each access.
- `host_wr`  in  1  host access is a write.
- `host_addr`  in  32  host byte address.
- `host_wdata`  in  32  host write data.
- `host_gnt`  out  1  host owns the port.
- `host_ack`  out  1  host access completes at this edge.
- `host_rdata`  out  32  read data to the host.
- `mem_wr`  out  1  to `dmem` write enable.
- `mem_addr`  out  32  to `dmem` address; `dmem` uses bits [31:2].
- `mem_wdata`  out  32  to `dmem` write data.
- `mem_rdata`  in  32  from `dmem` combinational read data.

## Operation
- The state register holds one of `CPU`, `HOST` or `COOL`. It uses two counters: `burst_cnt` and `cool_cnt`, each `$clog2` of its parameter, with a minimum width of 1.
- Owner mux:
  - In `HOST`, `mem_*` take the `host_*` values and `mem_wr = host_wr & host_req`.
  - Otherwise `mem_*` take the `cpu_*` values and `mem_wr = cpu_mem_wr & cpu_enable`.
  - `cpu_rdata` and `host_rdata` both equal `mem_rdata` at all times.
- Outputs by state:
  - `cpu_enable = run_in` in `CPU` and `COOL`, and `0` in `HOST`.
  - `host_gnt = (state==HOST)`.
  - `host_ack = host_gnt & host_req`.
- Transitions (evaluated at the rising edge):
  - `CPU`: if `host_req`, go to `HOST` with `burst_cnt=0`. The core instruction of that cycle commits normally.
  - `HOST`, `host_req=0`: go to `CPU`.
  - `HOST`, `host_req=1`, `burst_cnt==MAX_BURST-1`: go to `COOL` with `cool_cnt=CPU_SLOTS-1`.
  - `HOST`, `host_req=1`, otherwise: stay in `HOST` and increment `burst_cnt`.
  - `COOL`: `host_req` is ignored. If `cool_cnt==0`, go to `HOST` when `host_req=1` (with `burst_cnt=0`), else go to `CPU`. Otherwise decrement `cool_cnt`.
- The `COOL` window is counted in clock cycles regardless of `run_in`.
- Address and data pass through unmodified as 32 bits. The arbiter performs no alignment checks.

## Timing
- While reset is asserted and at reset release:
  - state=`CPU`, both counters 0.
  - `cpu_enable=0`, `host_gnt=0`, `host_ack=0`, `mem_wr=0`, all forced while reset is asserted.
- Reset asserted mid-burst aborts immediately. The host write in that cycle does not commit, because `mem_wr` is forced 0.
- Grant latency: `host_req` rising in cycle n, with state `CPU`, gives `host_gnt=1` from cycle n+1.
- Host access timing:
  - One access per cycle while granted.
  - A read is valid on `host_rdata` in the same cycle `host_ack=1`.
  - A write commits at the edge ending that cycle.
- The host holds `host_req` and its address/data stable until it sees `host_ack`. A request not acked (in `COOL`, or in `CPU` before the grant) performs no access.
- Release: when `host_req` falls in `HOST`, `cpu_enable` returns to `run_in` in the next cycle. One idle `HOST` cycle occurs, with no write and `host_ack=0`.
- Worst-case core stall is `MAX_BURST` cycles, followed by at least `CPU_SLOTS` core cycles.
- `MAX_BURST=1` alternates single-cycle `HOST` and `COOL` windows.

## Test plan
- **Reset:** hold reset low with `host_req=1` and `run_in=1` → `cpu_enable=0`, `host_gnt=0`, `mem_wr=0`. After release, the first cycle has `cpu_enable=1`, and `host_gnt=1` in the second cycle.
- **Host write/read:**
  - Host writes 0xDEADBEEF to 0x10, then reads 0x10 → `host_ack` is high on both cycles, `host_rdata=0xDEADBEEF`, and `cpu_enable=0` throughout.
  - The core's register and PC state is unchanged.
- **Burst limit** (`MAX_BURST=4`, `CPU_SLOTS=2`): hold `host_req` for 10 cycles → ack pattern 4 on / 2 off (`COOL`, `cpu_enable=1`) / 4 on.
- **Core write in COOL:** a core `sw` lands in a `COOL` slot and is not blocked. It is observed in `dmem` via a later host read.
- **Early release:** `host_req` is high for 2 cycles then falls → two acks, one idle `HOST` cycle with no write, then `CPU` with `cpu_enable=run_in`.
- **Reset mid-burst:** assert reset during the second host write to 0x20 → the word at 0x20 keeps its prior value. After release, state is `CPU` and `host_gnt=0`.
